// File: rtl/ble_packet_parser_pkg.sv
// Shared types and constants for the BLE packet parser.
// BLE_PARSER_CSUM_EN adds the GET_CSUM state (5-byte frame with XOR checksum).
package ble_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_SWING = 8'h01;
  localparam logic [7:0] CMD_PAN   = 8'h02;
  localparam logic [7:0] CMD_RESET = 8'h03;

`ifdef BLE_PARSER_CSUM_EN
  typedef enum logic [2:0] {
    HUNT,
    GET_CMD,
    GET_PHI,
    GET_PLO,
    GET_CSUM
  } parser_state_e;
`else
  typedef enum logic [1:0] {
    HUNT,
    GET_CMD,
    GET_PHI,
    GET_PLO
  } parser_state_e;
`endif

  function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                            input logic [7:0] phi,
                                            input logic [7:0] plo);
    return cmd ^ phi ^ plo;
  endfunction

endpackage

// File: rtl/ble_packet_parser_if.sv
// Byte-stream in / decoded-frame out bundle of the BLE packet parser.
// master = byte source and frame consumer, slave = parser.
interface ble_packet_parser_if;

  logic [7:0]  data_in;
  logic        valid_in;
  logic [7:0]  cmd_out;
  logic [15:0] payload_out;
  logic        valid_out;
  logic [7:0]  err_count_out;
  logic        busy_out;

  modport master (
    output data_in,
    output valid_in,
    input  cmd_out,
    input  payload_out,
    input  valid_out,
    input  err_count_out,
    input  busy_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output cmd_out,
    output payload_out,
    output valid_out,
    output err_count_out,
    output busy_out
  );

endinterface

// File: rtl/ble_packet_parser_core.sv
// Frame FSM and output registers of the BLE packet parser.
// BLE_PARSER_CSUM_EN selects the 5-byte checksummed frame; otherwise 4 bytes.
module ble_packet_parser_core
  import ble_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 742500
) (
  input  logic                clk,
  input  logic                rst_n,
  ble_packet_parser_if.slave  bus
);

  parser_state_e r_state;
  parser_state_e w_state_n;

  logic [7:0]  r_cmd;
  logic [7:0]  r_phi;
`ifdef BLE_PARSER_CSUM_EN
  logic [7:0]  r_plo;
  logic        w_csum_ok;
`endif

  logic [7:0]  r_cmd_out;
  logic [15:0] r_payload_out;
  logic        r_valid_out;
  logic [7:0]  r_err_cnt;

  logic        w_good;
  logic        w_err_inc;
  logic        w_timeout;
  logic        w_busy;
  logic [15:0] w_payload;

  assign w_busy = (r_state != HUNT);

  ble_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (bus.valid_in),
    .i_enable (w_busy),
    .o_expired(w_timeout)
  );

  always_comb begin
    w_state_n = r_state;
    w_good    = 1'b0;
    w_err_inc = 1'b0;
`ifdef BLE_PARSER_CSUM_EN
    w_payload = {r_phi, r_plo};
    w_csum_ok = (bus.data_in == frame_csum(r_cmd, r_phi, r_plo));
`else
    w_payload = {r_phi, bus.data_in};
`endif
    if (w_timeout) begin
      w_state_n = HUNT;
      w_err_inc = 1'b1;
    end else if (bus.valid_in) begin
      // Only HUNT looks for the sync byte; inside a frame every byte is data.
      case (r_state)
        HUNT:    if (bus.data_in == SYNC_BYTE) w_state_n = GET_CMD;
        GET_CMD: w_state_n = GET_PHI;
        GET_PHI: w_state_n = GET_PLO;
`ifdef BLE_PARSER_CSUM_EN
        GET_PLO: w_state_n = GET_CSUM;
        GET_CSUM: begin
          w_state_n = HUNT;
          if (w_csum_ok) w_good    = 1'b1;
          else           w_err_inc = 1'b1;
        end
`else
        GET_PLO: begin
          w_state_n = HUNT;
          w_good    = 1'b1;
        end
`endif
        default: w_state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
      r_phi <= '0;
`ifdef BLE_PARSER_CSUM_EN
      r_plo <= '0;
`endif
    end else if (bus.valid_in) begin
      case (r_state)
        GET_CMD: r_cmd <= bus.data_in;
        GET_PHI: r_phi <= bus.data_in;
`ifdef BLE_PARSER_CSUM_EN
        GET_PLO: r_plo <= bus.data_in;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_out     <= '0;
      r_payload_out <= '0;
      r_valid_out   <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_valid_out <= w_good;
      if (w_good) begin
        r_cmd_out     <= r_cmd;
        r_payload_out <= w_payload;
      end
      if (w_err_inc && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.cmd_out       = r_cmd_out;
  assign bus.payload_out   = r_payload_out;
  assign bus.valid_out     = r_valid_out;
  assign bus.err_count_out = r_err_cnt;
  assign bus.busy_out      = w_busy;

endmodule

// File: rtl/ble_packet_parser_gap_timer.sv
// Inter-byte gap timer: cleared by every accepted byte, counts while a frame
// is open, and flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module ble_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 742500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign o_expired = i_enable && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/ble_packet_parser.sv
// BLE packet parser top: SYNC, CMD, PHI, PLO [, CSUM] frames from uart_rx bytes.
// Define BLE_PARSER_CSUM_EN for the 5-byte checksummed frame format.
module ble_packet_parser
  import ble_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 742500
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic [7:0]  cmd_out,
  output logic [15:0] payload_out,
  output logic        valid_out,
  output logic [7:0]  err_count_out,
  output logic        busy_out
);

  ble_packet_parser_if u_bus ();

  assign u_bus.data_in  = data_in;
  assign u_bus.valid_in = valid_in;

  assign cmd_out       = u_bus.cmd_out;
  assign payload_out   = u_bus.payload_out;
  assign valid_out     = u_bus.valid_out;
  assign err_count_out = u_bus.err_count_out;
  assign busy_out      = u_bus.busy_out;

  ble_packet_parser_core #(
    .SYNC_BYTE     (SYNC_BYTE),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_core (
    .clk  (clk_in),
    .rst_n(rst_in),
    .bus  (u_bus.slave)
  );

endmodule

// File: tb/tb_ble_packet_parser.sv
// Directed bench for ble_packet_parser; good frames are queued as they are
// driven and matched against each valid_out pulse.
module tb_ble_packet_parser;

  localparam int unsigned TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ble_packet_parser_if tb_bus ();

  ble_packet_parser #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst_n),
    .data_in      (tb_bus.data_in),
    .valid_in     (tb_bus.valid_in),
    .cmd_out      (tb_bus.cmd_out),
    .payload_out  (tb_bus.payload_out),
    .valid_out    (tb_bus.valid_out),
    .err_count_out(tb_bus.err_count_out),
    .busy_out     (tb_bus.busy_out)
  );

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] pl;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          n_pulses  = 0;
  int          n_pushed  = 0;
  int          exp_err   = 0;
  logic [7:0]  last_cmd  = 8'h00;
  logic [15:0] last_pl   = 16'h0000;
  logic        prev_vout = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vout <= 1'b0;
    end else begin
      if (tb_bus.valid_out === 1'b1) begin
        n_pulses++;
        check("vout_single_cycle", {31'b0, prev_vout}, 32'd0);
        check("vout_expected", {31'b0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("sb_cmd", {24'b0, tb_bus.cmd_out}, {24'b0, mon_e.cmd});
          check("sb_payload", {16'b0, tb_bus.payload_out}, {16'b0, mon_e.pl});
        end
      end
      prev_vout <= tb_bus.valid_out;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    tb_bus.data_in  = b;
    tb_bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    tb_bus.valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_good(input logic [7:0] cmd, input logic [15:0] pl);
    sb_q.push_back({cmd, pl});
    n_pushed++;
    last_cmd = cmd;
    last_pl  = pl;
  endtask

  task automatic check_frame_end(input logic good);
    check("frame_latency", {31'b0, tb_bus.valid_out}, {31'b0, good});
    check("frame_cmd", {24'b0, tb_bus.cmd_out}, {24'b0, last_cmd});
    check("frame_payload", {16'b0, tb_bus.payload_out}, {16'b0, last_pl});
    check("frame_err", {24'b0, tb_bus.err_count_out}, exp_err);
    check("frame_busy", {31'b0, tb_bus.busy_out}, 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] phi,
                            input logic [7:0] plo, input logic good);
`ifdef BLE_PARSER_CSUM_EN
    logic [7:0] cs;
    cs = cmd ^ phi ^ plo;
`endif
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(phi);
`ifdef BLE_PARSER_CSUM_EN
    send_byte(plo);
    if (good) expect_good(cmd, {phi, plo});
    else if (exp_err < 255) exp_err++;
    send_byte(good ? cs : ~cs);
`else
    if (good) expect_good(cmd, {phi, plo});
    send_byte(plo);
`endif
    check_frame_end(good);
  endtask

  initial begin
    int p0;
    tb_bus.data_in  = 8'h00;
    tb_bus.valid_in = 1'b0;

    // Reset state
    idle(3);
    check("rst_cmd", {24'b0, tb_bus.cmd_out}, 32'd0);
    check("rst_payload", {16'b0, tb_bus.payload_out}, 32'd0);
    check("rst_vout", {31'b0, tb_bus.valid_out}, 32'd0);
    check("rst_err", {24'b0, tb_bus.err_count_out}, 32'd0);
    check("rst_busy", {31'b0, tb_bus.busy_out}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic good frame, then outputs must hold
    send_frame(8'h01, 8'h12, 8'h34, 1'b1);
    idle(4);
    check("hold_cmd", {24'b0, tb_bus.cmd_out}, 32'h01);
    check("hold_payload", {16'b0, tb_bus.payload_out}, 32'h1234);
    check("hold_vout", {31'b0, tb_bus.valid_out}, 32'd0);

`ifdef BLE_PARSER_CSUM_EN
    // Bad checksum: rejected, outputs unchanged
    send_frame(8'h01, 8'h12, 8'h34, 1'b0);
    idle(2);
`endif

    // Junk before sync, sync byte inside the frame treated as data
    p0 = n_pulses;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h02, 8'hA5, 8'h00, 1'b1);
    idle(2);
    check("junk_one_pulse", n_pulses - p0, 32'd1);

    // Timeout mid-frame; trailing bytes fall into HUNT and are discarded
    p0 = n_pulses;
    send_byte(8'hA5);
    check("busy_midframe", {31'b0, tb_bus.busy_out}, 32'd1);
    send_byte(8'h01);
    idle(TO);
    if (exp_err < 255) exp_err++;
    check("timeout_err", {24'b0, tb_bus.err_count_out}, exp_err);
    check("timeout_busy", {31'b0, tb_bus.busy_out}, 32'd0);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h27);
    idle(2);
    check("timeout_no_pulse", n_pulses - p0, 32'd0);
    check("timeout_err_hold", {24'b0, tb_bus.err_count_out}, exp_err);

    // Byte landing exactly on the expiry cycle is accepted
    send_byte(8'hA5);
    send_byte(8'h03);
    idle(TO - 1);
    send_byte(8'h56);
`ifdef BLE_PARSER_CSUM_EN
    send_byte(8'h78);
    expect_good(8'h03, 16'h5678);
    send_byte(8'h03 ^ 8'h56 ^ 8'h78);
`else
    expect_good(8'h03, 16'h5678);
    send_byte(8'h78);
`endif
    check_frame_end(1'b1);
    idle(1);

    // Back-to-back frames with no idle cycles
    p0 = n_pulses;
    send_frame(8'h01, 8'h00, 8'h01, 1'b1);
    send_frame(8'h02, 8'hFF, 8'h80, 1'b1);
    send_frame(8'h03, 8'hA5, 8'hA5, 1'b1);
    idle(2);
    check("b2b_pulses", n_pulses - p0, 32'd3);

    // Reset mid-frame discards the partial frame
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    rst_n    = 1'b0;
    exp_err  = 0;
    last_cmd = 8'h00;
    last_pl  = 16'h0000;
    idle(1);
    check("midrst_busy", {31'b0, tb_bus.busy_out}, 32'd0);
    check("midrst_cmd", {24'b0, tb_bus.cmd_out}, 32'd0);
    check("midrst_err", {24'b0, tb_bus.err_count_out}, 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    p0 = n_pulses;
    send_frame(8'h03, 8'h00, 8'h00, 1'b1);
    idle(2);
    check("postrst_pulses", n_pulses - p0, 32'd1);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
`ifdef BLE_PARSER_CSUM_EN
      send_frame(8'(i), 8'(i * 3), 8'h5A, 1'b0);
`else
      send_byte(8'hA5);
      idle(TO);
      if (exp_err < 255) exp_err++;
`endif
    end
    check("err_saturated", {24'b0, tb_bus.err_count_out}, 32'd255);
    check("err_model", {24'b0, tb_bus.err_count_out}, exp_err);
    check("sat_busy", {31'b0, tb_bus.busy_out}, 32'd0);

    idle(3);
    check("sb_drained", sb_q.size(), 32'd0);
    check("pulse_total", n_pulses, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
